// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader and the instruction memory.
package imem_loader_pkg;

   localparam int IMEM_DEPTH  = 1024;
   localparam int IMEM_ADDR_W = 10;

   // Payload bytes arrive least-significant byte first.
   localparam bit BYTE_ORDER_LE = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN0,
      S_LEN1,
      S_DATA,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles four stream bytes into one 32-bit word and flags the byte that completes it.
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_next,
   output logic        word_complete
);

   logic [1:0]  lane;
   logic [31:0] shreg;

   // Shifting right places the first byte in lane 0 once all four have arrived.
   assign word_next     = BYTE_ORDER_LE ? {byte_in, shreg[31:8]} : {shreg[23:0], byte_in};
   assign word_complete = byte_en && (lane == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane  <= 2'd0;
         shreg <= 32'd0;
      end else if (clear) begin
         lane  <= 2'd0;
         shreg <= 32'd0;
      end else if (byte_en) begin
         lane  <= lane + 2'd1;
         shreg <= word_next;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte image and writes it into instruction memory.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [15:0] DEPTH_L = 16'(DEPTH);

   state_t            state, state_nxt;
   logic [15:0]       len;
   logic [15:0]       len_rx;
   logic [7:0]        csum;
   logic [ADDR_W-1:0] widx;
   logic [ADDR_W:0]   wl_inc;
   logic              accept;
   logic              start_ok;
   logic              byte_en;
   logic [31:0]       word_next;
   logic              word_complete;

   assign in_ready = (state == S_LEN0) || (state == S_LEN1) ||
                     (state == S_DATA) || (state == S_CSUM);
   assign accept   = in_valid && in_ready;
   assign start_ok = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
   assign byte_en  = accept && (state == S_DATA);
   assign len_rx   = {in_data, len[7:0]};
   assign wl_inc   = words_loaded + 1'b1;

   imem_word_packer u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (start_ok),
      .byte_en      (byte_en),
      .byte_in      (in_data),
      .word_next    (word_next),
      .word_complete(word_complete)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_LEN0;
         S_LEN0: if (accept) state_nxt = S_LEN1;
         S_LEN1: begin
            if (accept) begin
               if (len_rx > DEPTH_L)      state_nxt = S_ERROR;
               else if (len_rx == 16'd0)  state_nxt = S_CSUM;
               else                       state_nxt = S_DATA;
            end
         end
         S_DATA:  if (word_complete) state_nxt = S_WRITE;
         S_WRITE: state_nxt = (16'(wl_inc) == len) ? S_CSUM : S_DATA;
         S_CSUM: begin
            if (accept) state_nxt = (in_data == csum) ? S_DONE : S_ERROR;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         len          <= 16'd0;
         csum         <= 8'd0;
         widx         <= '0;
         words_loaded <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= 32'd0;
         done         <= 1'b0;
         error        <= 1'b0;
         cpu_hold     <= 1'b0;
      end else begin
         state    <= state_nxt;
         done     <= (state_nxt == S_DONE);
         error    <= (state_nxt == S_ERROR);
         cpu_hold <= (state_nxt == S_LEN0) || (state_nxt == S_LEN1) || (state_nxt == S_DATA) ||
                     (state_nxt == S_WRITE) || (state_nxt == S_CSUM);
         mem_we   <= 1'b0;

         if (start_ok) begin
            len          <= 16'd0;
            csum         <= 8'd0;
            widx         <= '0;
            words_loaded <= '0;
         end
         if (accept && (state == S_LEN0)) len[7:0]  <= in_data;
         if (accept && (state == S_LEN1)) len[15:8] <= in_data;
         if (byte_en) csum <= csum + in_data;

         // Write strobe, address and data are registered together so they line up with WRITE.
         if (word_complete) begin
            mem_we    <= 1'b1;
            mem_addr  <= widx;
            mem_wdata <= word_next;
         end
         if (state == S_WRITE) begin
            words_loaded <= wl_inc;
            if (state_nxt == S_DATA) widx <= widx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole-image loads plus hand sequences for reset, start and full-depth corners.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int DEPTH  = 1024;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        in_data = 8'd0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .done(done), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   logic [ADDR_W-1:0] wr_addr[$];
   logic [31:0]       wr_data[$];
   logic prev_hs = 1'b0;
   logic prev_we = 1'b0;

   typedef struct {
      logic [15:0] n;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [7:0]  cs;
      int          gap;
      logic        exp_done;
      logic        exp_err;
      int          exp_words;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Every write strobe: one cycle wide, one cycle after a byte handshake, with in_ready low.
   always @(negedge clk) begin
      if (rst_n && mem_we) begin
         wr_addr.push_back(mem_addr);
         wr_data.push_back(mem_wdata);
         chk("we_after_byte", {31'd0, prev_hs}, 32'd1);
         chk("we_width", {31'd0, prev_we}, 32'd0);
         chk("we_in_ready", {31'd0, in_ready}, 32'd0);
      end
      prev_hs = rst_n && in_valid && in_ready;
      prev_we = mem_we;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      t = 0;
      in_valid = 1'b0;
      repeat (gap) step();
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && t < 100) begin
         step();
         t++;
      end
      if (t >= 100) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: in_ready stayed 0 for byte 0x%0h", b);
      end
      step();
      in_valid = 1'b0;
   endtask

   function automatic int pick_gap(input int mode);
      return (mode == 0) ? 0 : int'($urandom_range(0, 3));
   endfunction

   task automatic wait_end(input string tag);
      int t;
      t = 0;
      while (!(done || error) && t < 20) begin
         step();
         t++;
      end
      if (t >= 20) begin
         tests++;
         fails++;
         $display("FAIL %s_end_timeout: done=%0b error=%0b", tag, done, error);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [31:0] w[2];
      int          nexp;
      w[0] = v.w0;
      w[1] = v.w1;
      wr_addr.delete();
      wr_data.delete();
      pulse_start();
      chk({tag, "_hold_on"}, {31'd0, cpu_hold}, 32'd1);
      chk({tag, "_flags_clr"}, {30'd0, done, error}, 32'd0);
      send_byte(v.n[7:0], pick_gap(v.gap));
      send_byte(v.n[15:8], pick_gap(v.gap));
      if (int'(v.n) <= DEPTH) begin
         for (int i = 0; i < int'(v.n) && i < 2; i++)
            for (int k = 0; k < 4; k++)
               send_byte(w[i][8*k +: 8], pick_gap(v.gap));
         send_byte(v.cs, pick_gap(v.gap));
      end
      wait_end(tag);
      nexp = (int'(v.n) <= DEPTH) ? int'(v.n) : 0;
      chk({tag, "_done"}, {31'd0, done}, {31'd0, v.exp_done});
      chk({tag, "_error"}, {31'd0, error}, {31'd0, v.exp_err});
      chk({tag, "_words"}, 32'(words_loaded), v.exp_words);
      chk({tag, "_hold_off"}, {31'd0, cpu_hold}, 32'd0);
      chk({tag, "_ready_off"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_nwrites"}, wr_data.size(), nexp);
      for (int i = 0; i < wr_data.size() && i < 2; i++) begin
         chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), i);
         chk($sformatf("%s_data%0d", tag, i), wr_data[i], w[i]);
      end
   endtask

   function automatic logic [31:0] big_word(input int i);
      return 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
   endfunction

   initial begin : main
      logic [7:0]  cs;
      logic [31:0] w;
      int          nmis;

      vecs[0] = '{16'd2,      32'h0000_0013, 32'h0010_0093, 8'hB6, 0, 1'b1, 1'b0, 2};
      vecs[1] = '{16'd2,      32'h0000_0013, 32'h0010_0093, 8'hB5, 0, 1'b0, 1'b1, 2};
      vecs[2] = '{16'h0401,   32'h0,         32'h0,         8'h00, 0, 1'b0, 1'b1, 0};
      vecs[3] = '{16'd0,      32'h0,         32'h0,         8'h00, 0, 1'b1, 1'b0, 0};
      vecs[4] = '{16'd1,      32'hFFFF_FFFF, 32'h0,         8'hFC, 1, 1'b1, 1'b0, 1};
      vecs[5] = '{16'd2,      32'h8080_8080, 32'h0102_0304, 8'h0A, 1, 1'b1, 1'b0, 2};
      vecs[6] = '{16'd0,      32'h0,         32'h0,         8'h01, 1, 1'b0, 1'b1, 0};

      #2;
      chk("rst_outputs", {in_ready, mem_we, cpu_hold, done, error}, 32'd0);
      chk("rst_addr_data", mem_wdata | 32'(mem_addr) | 32'(words_loaded), 32'd0);
      #10 rst_n = 1'b1;
      step();

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset in the middle of the second word: everything clears at once.
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
      send_byte(8'h55, 0); send_byte(8'h66, 0);
      chk("pre_rst_words", 32'(words_loaded), 32'd1);
      chk("pre_rst_wdata", mem_wdata, 32'h4433_2211);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_ctl", {in_ready, mem_we, cpu_hold, done, error}, 32'd0);
      chk("async_rst_wdata", mem_wdata, 32'd0);
      chk("async_rst_addr_words", 32'(mem_addr) | 32'(words_loaded), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      run_vec('{16'd1, 32'hDEAD_BEEF, 32'h0, 8'h38, 0, 1'b1, 1'b0, 1}, "after_rst");

      // start inside DATA must be ignored.
      wr_data.delete();
      wr_addr.delete();
      pulse_start();
      send_byte(8'h01, 0); send_byte(8'h00, 0);
      send_byte(8'h44, 0); send_byte(8'h33, 0);
      pulse_start();
      send_byte(8'h22, 1); send_byte(8'h11, 0);
      send_byte(8'hAA, 0);
      wait_end("mid_start");
      chk("mid_start_done", {31'd0, done}, 32'd1);
      chk("mid_start_nwrites", wr_data.size(), 1);
      if (wr_data.size() > 0) chk("mid_start_data", wr_data[0], 32'h1122_3344);

      // Bytes offered while in_ready is low are not consumed.
      in_data = 8'h55;
      in_valid = 1'b1;
      repeat (3) step();
      in_valid = 1'b0;
      chk("idle_valid_words", 32'(words_loaded), 32'd1);
      chk("idle_valid_done", {31'd0, done}, 32'd1);

      // start from DONE begins a new load.
      pulse_start();
      chk("reload_done_clr", {31'd0, done}, 32'd0);
      chk("reload_words_clr", 32'(words_loaded), 32'd0);
      chk("reload_ready", {30'd0, in_ready, cpu_hold}, 32'd3);
      send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      wait_end("reload");
      chk("reload_done", {31'd0, done}, 32'd1);

      // Full-depth image: last write lands at DEPTH-1.
      wr_data.delete();
      wr_addr.delete();
      cs = 8'd0;
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h04, 0);
      for (int i = 0; i < DEPTH; i++) begin
         w = big_word(i);
         for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], 0);
            cs = cs + w[8*k +: 8];
         end
      end
      send_byte(cs, 0);
      wait_end("full");
      chk("full_done", {30'd0, done, error}, 32'd2);
      chk("full_words", 32'(words_loaded), DEPTH);
      chk("full_nwrites", wr_data.size(), DEPTH);
      nmis = 0;
      for (int i = 0; i < wr_data.size(); i++)
         if (wr_data[i] !== big_word(i) || 32'(wr_addr[i]) !== 32'(i)) nmis++;
      chk("full_content_mismatches", nmis, 0);
      if (wr_addr.size() == DEPTH) chk("full_last_addr", 32'(wr_addr[DEPTH-1]), DEPTH - 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory. It receives a program image as a byte stream (for example from a UART receiver) and assembles the bytes into 32-bit little-endian words.
- Each completed word is written into the instruction memory write port, starting at word 0.
- While loading, the block holds the core in reset, then signals done or error.
- Sits between the boot byte source and the instruction memory; the core's fetch path is unaffected.

Parameters:
- DEPTH, 1024, instruction memory depth in words; also the maximum accepted image length.
- ADDR_W, 10, word-index width; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_W  word index for the write.
- mem_wdata  output  32  word to write.
- cpu_hold  output  1  holds the core in reset while loading.
- done  output  1  image loaded and checksum matched.
- error  output  1  length overflow or checksum mismatch.
- words_loaded  output  ADDR_W+1  count of words written in the current or last load.

Behaviour:
- Reset, asynchronous: state=IDLE and every output 0, including mem_addr, mem_wdata and words_loaded; internal length, byte counter, checksum and shift register cleared.
- A byte transfers on any rising edge where in_valid and in_ready are both 1.
- Image format: LEN_LO, LEN_HI (16-bit word count N), then 4*N payload bytes (least-significant byte of each word first), then CSUM.
- CSUM = 8-bit wrapping sum of the payload bytes only.
- States:
  - IDLE: in_ready=0. start goes to LEN0 and clears the checksum, words_loaded, the word index and done/error.
  - LEN0: in_ready=1; accept LEN_LO, go to LEN1.
  - LEN1: in_ready=1; accept LEN_HI. If N > DEPTH, go to ERROR. If N=0, go to CSUM. Otherwise go to DATA.
  - DATA: in_ready=1. Each accepted byte is shifted into byte lane 0..3 in arrival order and added to the checksum. On the 4th byte, go to WRITE.
  - WRITE: in_ready=0. mem_we=1 for exactly one cycle, with mem_addr=current word index and mem_wdata=the assembled word. The word index and words_loaded increment. If words_loaded (after increment) equals N, go to CSUM; otherwise go to DATA.
  - CSUM: in_ready=1; accept one byte. If it equals the running sum, go to DONE; otherwise go to ERROR.
  - DONE: done=1, in_ready=0.
  - ERROR: error=1, in_ready=0.
  - From DONE or ERROR, start behaves exactly as from IDLE.
- cpu_hold=1 in LEN0, LEN1, DATA, WRITE and CSUM; 0 in IDLE, DONE and ERROR.
- done, error and cpu_hold are registered, decoded from state. At most one of done/error is 1.
- Latency: mem_we asserts on the cycle after the 4th byte of a word is accepted. Peak throughput is 4 bytes per 5 cycles.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Boundaries:
  - start outside IDLE/DONE/ERROR is ignored.
  - in_valid with in_ready=0 does not transfer; the source must hold its byte.
  - N=DEPTH is legal; the last write goes to address DEPTH-1.
  - The word index never wraps, because N is checked at LEN1.
  - rst_n falling mid-load aborts immediately: the returned state is IDLE, cpu_hold=0, and any partial word is discarded.
  - Checksum addition wraps at 8 bits.

Decomposition:
- Shared package contains:
  - the state enumeration (IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERROR);
  - IMEM_DEPTH=1024 and IMEM_ADDR_W=10, also used by the instruction memory;
  - the little-endian byte-order constant.
- One sub-module is natural: imem_word_packer, which contains the 2-bit byte-lane counter, the 32-bit shift register and the word-complete flag.
- The FSM, checksum and counters stay in the top level.

Test Plan:
- Reset, then start; stream 02 00, 13 00 00 00, 93 00 10 00, CSUM 0xB6 → writes 0x00000013 at addr 0 and 0x00100093 at addr 1, done=1, error=0, words_loaded=2, cpu_hold falls on entry to DONE.
- Same image with CSUM 0xB5 → both writes occur, then error=1, done=0.
- Length 0x0401 (1025 > DEPTH) → no mem_we, error=1 after LEN_HI is accepted; with length 0x0000 and CSUM 00 → done=1, words_loaded=0.
- Random in_valid gaps, plus confirming in_ready=0 during each WRITE cycle → no byte lost or duplicated; each mem_we is exactly one cycle wide and comes one cycle after the 4th byte.
- rst_n pulsed low after 6 payload bytes → all outputs 0 asynchronously; a subsequent fresh 1-word load writes at addr 0 correctly.
- start pulsed during DATA → ignored; start from DONE → reload begins, done clears, words_loaded resets to 0.
